imem_loader: RTL and testbench

Boot-time program loader for `pipeline_cpu`. Accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially into the instruction memory write port. Holds the CPU in reset until the image is complete, then releases it. It is the hardware counterpart of the bench-side `$readmemh` image load, and supports re-loading a new program at run time.

---
 rtl/loader_pkg.sv | 19 +
 rtl/loader_word_asm.sv | 38 +++
 rtl/imem_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared types and sizes for the instruction-memory boot loader.
// Holds the loader state encoding and the frame geometry constants.
package loader_pkg;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;
   localparam int CNT_W      = 8 * HDR_BYTES;

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_CSUM,
      S_FLUSH,
      S_RUN,
      S_ERR
   } ld_state_t;

endpackage

// File: rtl/loader_word_asm.sv
// loader_word_asm: big-endian byte-to-word assembler for the boot loader.
// word_done flags the byte that completes a word; word is valid with it.
module loader_word_asm
   import loader_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic        word_done,
   output logic [31:0] word
);

   localparam int CW = $clog2(WORD_BYTES);
   localparam int SW = 8 * (WORD_BYTES - 1);

   logic [CW-1:0] cnt;
   logic [SW-1:0] sh;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         sh  <= '0;
      end else if (clear) begin
         cnt <= '0;
         sh  <= '0;
      end else if (byte_en) begin
         cnt <= cnt + CW'(1);
         sh  <= {sh[SW-9:0], byte_in};
      end
   end

   // The final byte bypasses the shifter so the word is ready on its edge.
   assign word_done = byte_en && (cnt == CW'(WORD_BYTES - 1));
   assign word      = {sh, byte_in};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader for the instruction memory.
// Define IMEM_LOADER_CSUM_EN to expect a trailing XOR checksum byte.
module imem_loader
   import loader_pkg::*;
#(
   parameter int IM_AW = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   input  logic             load_req,
   output logic             im_we,
   output logic [IM_AW-1:0] im_addr,
   output logic [31:0]      im_wdata,
   output logic             cpu_enable,
   output logic             busy,
   output logic             err,
   output logic [IM_AW:0]   words_loaded
);

`ifdef IMEM_LOADER_CSUM_EN
   localparam ld_state_t POST = S_CSUM;
`else
   localparam ld_state_t POST = S_FLUSH;
`endif

   ld_state_t        state;
   ld_state_t        state_nx;
   logic [CNT_W-1:0] n_q;
   logic [CNT_W-1:0] hdr_n;
   logic             accept;
   logic             restart;
   logic             oversize;
   logic             last_word;
   logic             asm_en;
   logic             word_done;
   logic [31:0]      word;
   logic             rx_ready_d;
   logic             busy_d;
   logic             cpu_d;
   logic             err_d;

   assign accept    = rx_valid && rx_ready;
   assign restart   = load_req && (state == S_RUN || state == S_ERR);
   assign asm_en    = accept && (state == S_DATA);
   assign hdr_n     = {n_q[CNT_W-1:8], rx_data};
   assign oversize  = 32'(hdr_n) > (32'd1 << IM_AW);
   assign last_word = (32'(words_loaded) + 32'd1) == 32'(n_q);

   loader_word_asm u_asm (
      .clock     (clock),
      .reset     (reset),
      .clear     (restart),
      .byte_en   (asm_en),
      .byte_in   (rx_data),
      .word_done (word_done),
      .word      (word)
   );

`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0] csum;

   // Running XOR of every accepted byte before the checksum itself.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         csum <= '0;
      else if (restart)
         csum <= '0;
      else if (accept)
         csum <= csum ^ rx_data;
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= S_HDR0;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_HDR0:
            if (accept)
               state_nx = S_HDR1;
         S_HDR1:
            if (accept) begin
               if (oversize)
                  state_nx = S_ERR;
               else if (hdr_n == '0)
                  state_nx = POST;
               else
                  state_nx = S_DATA;
            end
         S_DATA:
            if (word_done && last_word)
               state_nx = POST;
`ifdef IMEM_LOADER_CSUM_EN
         S_CSUM:
            if (accept)
               state_nx = (rx_data == csum) ? S_RUN : S_ERR;
`endif
         S_FLUSH:
            state_nx = S_RUN;
         S_RUN, S_ERR:
            if (load_req)
               state_nx = S_HDR0;
         default:
            state_nx = S_HDR0;
      endcase
   end

   // Outputs are decoded from the next state so they register in step.
   always_comb begin
      rx_ready_d = 1'b0;
      busy_d     = 1'b1;
      cpu_d      = 1'b0;
      err_d      = 1'b0;
      unique case (state_nx)
         S_HDR0, S_HDR1, S_DATA, S_CSUM:
            rx_ready_d = 1'b1;
         S_RUN: begin
            busy_d = 1'b0;
            cpu_d  = 1'b1;
         end
         S_ERR: begin
            busy_d = 1'b0;
            err_d  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_ready   <= 1'b0;
         busy       <= 1'b1;
         cpu_enable <= 1'b0;
         err        <= 1'b0;
         im_we      <= 1'b0;
      end else begin
         rx_ready   <= rx_ready_d;
         busy       <= busy_d;
         cpu_enable <= cpu_d;
         err        <= err_d;
         im_we      <= word_done;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         n_q          <= '0;
         words_loaded <= '0;
         im_addr      <= '0;
         im_wdata     <= '0;
      end else begin
         if (accept && state == S_HDR0)
            n_q[CNT_W-1:8] <= rx_data;
         if (accept && state == S_HDR1)
            n_q[7:0] <= rx_data;
         if (restart) begin
            words_loaded <= '0;
         end else if (word_done) begin
            im_addr      <= words_loaded[IM_AW-1:0];
            im_wdata     <= word;
            words_loaded <= words_loaded + (IM_AW+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame loads checked against a word-level model.
// Honours IMEM_LOADER_CSUM_EN to append and corrupt checksum bytes.
module tb_imem_loader;

   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;
`ifdef IMEM_LOADER_CSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          load_req;
   logic          im_we;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_wdata;
   logic          cpu_enable;
   logic          busy;
   logic          err;
   logic [AW:0]   words_loaded;

   int            total = 0;
   int            bad = 0;
   int            wr_cnt = 0;
   logic [31:0]   dut_mem [DEPTH];
   logic [31:0]   exp_mem [DEPTH];
   logic [31:0]   fw [$];

   always #5 clock = ~clock;

   imem_loader #(.IM_AW(AW)) dut (
      .clock        (clock),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .load_req     (load_req),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .cpu_enable   (cpu_enable),
      .busy         (busy),
      .err          (err),
      .words_loaded (words_loaded)
   );

   // Bench-side instruction memory fed by the write port.
   always @(posedge clock) begin
      if (im_we) begin
         wr_cnt++;
         dut_mem[im_addr] = im_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rdy"},  32'(rx_ready),     0);
      chk({tag, "_we"},   32'(im_we),        0);
      chk({tag, "_cpu"},  32'(cpu_enable),   0);
      chk({tag, "_err"},  32'(err),          0);
      chk({tag, "_busy"}, 32'(busy),         1);
      chk({tag, "_addr"}, 32'(im_addr),      0);
      chk({tag, "_wd"},   im_wdata,          0);
      chk({tag, "_wl"},   32'(words_loaded), 0);
   endtask

   task automatic push(input logic [7:0] b, input int gap);
      int t = 0;
      repeat (gap) begin
         @(negedge clock);
         rx_valid = 1'b0;
      end
      @(negedge clock);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && t < 40) begin
         @(negedge clock);
         t++;
      end
      if (!rx_ready)
         chk("rx_timeout", 32'(rx_ready), 1);
      @(posedge clock);
      #1;
   endtask

   task automatic restart(input string tag);
      @(negedge clock);
      rx_valid = 1'b0;
      load_req = 1'b1;
      @(posedge clock);
      #1;
      chk({tag, "_cpu"},  32'(cpu_enable),   0);
      chk({tag, "_err"},  32'(err),          0);
      chk({tag, "_rdy"},  32'(rx_ready),     1);
      chk({tag, "_busy"}, 32'(busy),         1);
      chk({tag, "_wl"},   32'(words_loaded), 0);
      @(negedge clock);
      load_req = 1'b0;
   endtask

   task automatic fill(input int n);
      fw.delete();
      if (n <= DEPTH)
         for (int i = 0; i < n; i++)
            fw.push_back($urandom);
   endtask

   task automatic run_frame(input int n, input int glo, input int ghi,
                            input bit badsum);
      logic [15:0] nn;
      logic [7:0]  cs;
      logic [7:0]  b;
      int          w0;
      bit          eb;
      eb = badsum && CSUM;
      w0 = wr_cnt;
      nn = n[15:0];
      cs = nn[15:8] ^ nn[7:0];
      push(nn[15:8], int'($urandom_range(ghi, glo)));
      push(nn[7:0],  int'($urandom_range(ghi, glo)));
      if (n > DEPTH) begin
         chk("ovf_err",  32'(err),        1);
         chk("ovf_rdy",  32'(rx_ready),   0);
         chk("ovf_cpu",  32'(cpu_enable), 0);
         chk("ovf_busy", 32'(busy),       0);
         @(negedge clock);
         rx_valid = 1'b0;
         repeat (3) @(posedge clock);
         #1;
         chk("ovf_err_hold", 32'(err),        1);
         chk("ovf_cpu_hold", 32'(cpu_enable), 0);
         chk("ovf_nowr",     32'(wr_cnt - w0), 0);
         return;
      end
      for (int i = 0; i < n; i++)
         for (int j = 0; j < 4; j++) begin
            b = fw[i][31 - 8*j -: 8];
            cs ^= b;
            push(b, int'($urandom_range(ghi, glo)));
         end
`ifdef IMEM_LOADER_CSUM_EN
      push(cs ^ 8'(eb), int'($urandom_range(ghi, glo)));
      chk("cs_cpu",  32'(cpu_enable),   32'(!eb));
      chk("cs_err",  32'(err),          32'(eb));
      chk("cs_busy", 32'(busy),         0);
      chk("cs_rdy",  32'(rx_ready),     0);
      chk("cs_we",   32'(im_we),        0);
      chk("cs_wl",   32'(words_loaded), 32'(n));
`else
      if (n > 0) begin
         chk("last_we",   32'(im_we),   1);
         chk("last_addr", 32'(im_addr), 32'(n - 1));
         chk("last_wd",   im_wdata,     fw[n-1]);
      end
      chk("fl_rdy",  32'(rx_ready),   0);
      chk("fl_busy", 32'(busy),       1);
      chk("fl_cpu",  32'(cpu_enable), 0);
      @(posedge clock);
      #1;
      chk("run_cpu",  32'(cpu_enable),   1);
      chk("run_we",   32'(im_we),        0);
      chk("run_busy", 32'(busy),         0);
      chk("run_err",  32'(err),          0);
      chk("run_rdy",  32'(rx_ready),     0);
      chk("run_wl",   32'(words_loaded), 32'(n));
`endif
      @(negedge clock);
      rx_valid = 1'b0;
      for (int i = 0; i < n; i++)
         exp_mem[i] = fw[i];
      chk("wr_count", 32'(wr_cnt - w0), 32'(n));
      for (int i = 0; i < DEPTH; i++)
         chk($sformatf("mem%0d", i), dut_mem[i], exp_mem[i]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int r;
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = '0;
      load_req = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         dut_mem[i] = '0;
         exp_mem[i] = '0;
      end
      repeat (3) @(negedge clock);
      chk_reset("rst");
      reset = 1'b0;
      #1;
      chk("rdy_pre", 32'(rx_ready), 0);
      @(posedge clock);
      #1;
      chk("rdy_post", 32'(rx_ready), 1);

      fw = {32'h20080005, 32'h01095020};
      run_frame(2, 0, 0, 1'b0);
      restart("rs_run");
      run_frame(2, 2, 2, 1'b0);

      restart("rs_img2");
      fw = {32'hAC090000};
      run_frame(1, 0, 0, 1'b0);

      restart("rs_ovf");
      run_frame(17, 0, 0, 1'b0);

      restart("rs_err");
      fw.delete();
      run_frame(0, 0, 0, 1'b0);

      restart("rs_full");
      fill(DEPTH);
      run_frame(DEPTH, 0, 1, 1'b0);

      restart("rs_mid");
      fill(2);
      push(8'h00, 0);
      push(8'h02, 0);
      push(fw[0][31:24], 0);
      push(fw[0][23:16], 0);
      @(negedge clock);
      rx_valid = 1'b0;
      reset    = 1'b1;
      #1;
      chk_reset("midrst");
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("mid_rdy", 32'(rx_ready), 1);
      fill(2);
      run_frame(2, 0, 1, 1'b0);

`ifdef IMEM_LOADER_CSUM_EN
      restart("rs_csok");
      fw = {32'h12345678};
      run_frame(1, 0, 0, 1'b0);
      restart("rs_csbad");
      run_frame(1, 0, 0, 1'b1);
`endif

      for (int it = 0; it < 10; it++) begin
         restart($sformatf("rs_rnd%0d", it));
         r = int'($urandom_range(9, 0));
         if (r == 0)
            n = 0;
         else if (r == 1)
            n = int'($urandom_range(65535, DEPTH + 1));
         else if (r == 2)
            n = DEPTH;
         else
            n = int'($urandom_range(DEPTH, 1));
         fill(n);
         run_frame(n, 0, 3, bit'($urandom_range(1, 0)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
